// File: rtl/icache_pkg.sv
// Shared types and width helpers for the set-associative instruction cache.
package icache_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    MISS  = 2'd1,
    FLUSH = 2'd2
  } state_t;

  function automatic int offs_w(input int line_bits);
    return $clog2(line_bits / 8);
  endfunction

  function automatic int idx_w(input int sets);
    return $clog2(sets);
  endfunction

  function automatic int tag_w(input int xlen, input int line_bits, input int sets);
    return xlen - offs_w(line_bits) - idx_w(sets);
  endfunction

endpackage

// File: rtl/icache_if.sv
// Fetch-side and memory-bus signals of the instruction cache.
interface icache_if #(
  parameter int XLEN      = 64,
  parameter int LINE_BITS = 1024
);
  logic [XLEN-1:0]      pc;
  logic                 pc_vld;
  logic [31:0]          ir;
  logic                 ir_vld;
  logic                 stall;
  logic                 fence_i;
  logic                 fence_done;
  logic [XLEN-1:0]      b_addr;
  logic                 b_rd;
  logic [LINE_BITS-1:0] b_data;
  logic                 b_dv;

  modport master (
    output pc, pc_vld, fence_i, b_data, b_dv,
    input  ir, ir_vld, stall, fence_done, b_addr, b_rd
  );

  modport slave (
    input  pc, pc_vld, fence_i, b_data, b_dv,
    output ir, ir_vld, stall, fence_done, b_addr, b_rd
  );
endinterface

// File: rtl/icache_plru_tree.sv
// Tree pseudo-LRU for one set: victim choice (invalid ways first) and bit update on access.
module plru_tree #(
  parameter int WAYS = 4,
  localparam int WW  = $clog2(WAYS)
) (
  input  logic [WAYS-2:0] bits,
  input  logic [WAYS-1:0] valid,
  input  logic [WW-1:0]   acc_way,
  output logic [WW-1:0]   victim,
  output logic [WAYS-2:0] next_bits
);

  logic found;

  always_comb begin
    victim = '0;
    found  = 1'b0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (!valid[w]) begin
        victim = WW'(w);
        found  = 1'b1;
      end
    end
    // Heap walk: node of level l at position p is (2^l - 1) + p, p = path prefix so far.
    if (!found) begin
      for (int l = 0; l < WW; l++) begin
        for (int p = 0; p < (1 << l); p++) begin
          if ((victim >> (WW - l)) == WW'(p))
            victim[WW-1-l] = bits[(1 << l) - 1 + p];
        end
      end
    end
  end

  always_comb begin
    next_bits = bits;
    for (int l = 0; l < WW; l++) begin
      for (int p = 0; p < (1 << l); p++) begin
        if ((acc_way >> (WW - l)) == WW'(p))
          next_bits[(1 << l) - 1 + p] = ~acc_way[WW-1-l];
      end
    end
  end

endmodule

// File: rtl/icache.sv
// Set-associative instruction cache: 0-cycle hits, registered line-fill miss FSM, fence.i flush walk.
//   state | meaning
//   IDLE  | serving hits, launching misses or flushes
//   MISS  | b_rd held until the fill line arrives
//   FLUSH | clearing valid/PLRU bits one set per cycle
module icache
  import icache_pkg::*;
#(
  parameter int XLEN      = 64,
  parameter int LINE_BITS = 1024,
  parameter int SETS      = 4,
  parameter int WAYS      = 4
) (
  input  logic    clk,
  input  logic    clr,
  icache_if.slave bus
);

  localparam int OFFS = offs_w(LINE_BITS);
  localparam int IDX  = idx_w(SETS);
  localparam int TAG  = tag_w(XLEN, LINE_BITS, SETS);
  localparam int WW   = $clog2(WAYS);

  state_t state, state_nx;

  logic [LINE_BITS-1:0] data_q  [SETS][WAYS];
  logic [TAG-1:0]       tag_q   [SETS][WAYS];
  logic [WAYS-1:0]      valid_q [SETS];
  logic [WAYS-2:0]      plru_q  [SETS];

  logic [IDX-1:0]  pc_idx, miss_idx, flush_idx, cur_idx;
  logic [TAG-1:0]  pc_tag, miss_tag;
  logic [OFFS-3:0] word_sel;
  logic [$clog2(LINE_BITS)-1:0] word_base;
  logic [WW-1:0]   hit_way, victim, victim_q, acc_way;
  logic [WAYS-2:0] plru_nx;
  logic [XLEN-1:0] b_addr_q;
  logic            hit, hit_now, fill, flush_en, fence_pend, fence_done_q;
  logic            unused_pc_lsb;

  assign pc_idx        = bus.pc[OFFS +: IDX];
  assign pc_tag        = bus.pc[XLEN-1 -: TAG];
  assign word_sel      = bus.pc[OFFS-1:2];
  assign word_base     = {word_sel, 5'b0};
  assign unused_pc_lsb = ^bus.pc[1:0];

  // Lowest matching way wins by scanning downward.
  always_comb begin
    hit     = 1'b0;
    hit_way = '0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (valid_q[pc_idx][w] && tag_q[pc_idx][w] == pc_tag) begin
        hit     = 1'b1;
        hit_way = WW'(w);
      end
    end
  end

  plru_tree #(.WAYS(WAYS)) u_plru (
    .bits      (plru_q[cur_idx]),
    .valid     (valid_q[cur_idx]),
    .acc_way   (acc_way),
    .victim    (victim),
    .next_bits (plru_nx)
  );

  always_ff @(posedge clk or posedge clr) begin
    if (clr) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (bus.fence_i)             state_nx = FLUSH;
               else if (bus.pc_vld && !hit) state_nx = MISS;
      MISS:    if (bus.b_dv)                state_nx = (fence_pend || bus.fence_i) ? FLUSH : IDLE;
      FLUSH:   if (flush_idx == IDX'(SETS - 1)) state_nx = IDLE;
      default:                              state_nx = IDLE;
    endcase
  end

  always_comb begin
    hit_now        = (state == IDLE) && bus.pc_vld && hit;
    bus.ir_vld     = hit_now;
    bus.ir         = data_q[pc_idx][hit_way][word_base +: 32];
    bus.stall      = (bus.pc_vld && !hit_now) || (state != IDLE);
    bus.b_rd       = (state == MISS);
    bus.b_addr     = b_addr_q;
    bus.fence_done = fence_done_q;
    fill           = (state == MISS) && bus.b_dv;
    flush_en       = (state == FLUSH);
    cur_idx        = (state == MISS) ? miss_idx : pc_idx;
    acc_way        = (state == MISS) ? victim_q : hit_way;
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      b_addr_q     <= '0;
      miss_idx     <= '0;
      miss_tag     <= '0;
      victim_q     <= '0;
      fence_pend   <= 1'b0;
      flush_idx    <= '0;
      fence_done_q <= 1'b0;
      for (int s = 0; s < SETS; s++) begin
        valid_q[s] <= '0;
        plru_q[s]  <= '0;
      end
    end else begin
      fence_done_q <= 1'b0;
      if (state == IDLE && state_nx == MISS) begin
        b_addr_q <= {bus.pc[XLEN-1:OFFS], OFFS'(0)};
        miss_idx <= pc_idx;
        miss_tag <= pc_tag;
        victim_q <= victim;
      end
      if (state == MISS && bus.fence_i) fence_pend <= 1'b1;
      // Entering FLUSH consumes any pending fence and restarts the walk.
      if (state != FLUSH && state_nx == FLUSH) begin
        fence_pend <= 1'b0;
        flush_idx  <= '0;
      end
      if (fill) begin
        valid_q[miss_idx][victim_q] <= 1'b1;
        plru_q[miss_idx]            <= plru_nx;
      end
      if (hit_now) plru_q[pc_idx] <= plru_nx;
      if (flush_en) begin
        valid_q[flush_idx] <= '0;
        plru_q[flush_idx]  <= '0;
        flush_idx          <= flush_idx + 1'b1;
        if (flush_idx == IDX'(SETS - 1)) fence_done_q <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (fill) begin
      data_q[miss_idx][victim_q] <= bus.b_data;
      tag_q[miss_idx][victim_q]  <= miss_tag;
    end
  end

endmodule
